// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges two producers into one register-file write port
// through a small in-order FIFO, tracking pending destinations.
module wb_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     a_valid,
  input  logic [4:0]               a_addr,
  input  logic [31:0]              a_data,
  output logic                     a_ready,
  input  logic                     b_valid,
  input  logic [4:0]               b_addr,
  input  logic [31:0]              b_data,
  output logic                     b_ready,
  output logic                     write,
  output logic [4:0]               addrssw,
  output logic [31:0]              write_material,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [4:0]    addr_q [DEPTH];
  logic [4:0]    addr_d [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [31:0]   data_d [DEPTH];

  logic [CW-1:0] cnt_eff;
  logic [CW-1:0] free;
  logic          pop;
  logic          a_enq;
  logic          b_enq;
  logic [PW-1:0] bslot;
  logic [PW-1:0] idx;

  // Reset cycles look like an empty queue to the producers
  always_comb begin
    cnt_eff = rst ? '0 : count_q;
    pop     = (cnt_eff != '0);
    free    = CW'(DEPTH) - cnt_eff + CW'(pop);
    a_ready = (free >= CW'(1));
    b_ready = (free >= CW'(2)) ||
              ((free >= CW'(1)) && !a_valid);
    a_enq   = a_valid && a_ready &&
              (a_addr != 5'd0) && !rst;
    b_enq   = b_valid && b_ready && !rst;
  end

  always_comb begin
    write          = pop;
    addrssw        = pop ? addr_q[rptr_q] : 5'd0;
    write_material = pop ? data_q[rptr_q] : 32'd0;
    count          = count_q;
    pending        = '0;
    idx            = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr_q + PW'(k);
      if (CW'(k) < cnt_eff)
        pending[addr_q[idx]] = 1'b1;
    end
  end

  // A is always placed ahead of B within the same cycle
  always_comb begin
    addr_d = addr_q;
    data_d = data_q;
    bslot  = wptr_q + PW'(a_enq);
    if (a_enq) begin
      addr_d[wptr_q] = a_addr;
      data_d[wptr_q] = a_data;
    end
    if (b_enq) begin
      addr_d[bslot] = b_addr;
      data_d[bslot] = b_data;
    end
    wptr_d  = wptr_q + PW'(a_enq) + PW'(b_enq);
    rptr_d  = rptr_q + PW'(pop);
    count_d = cnt_eff + CW'(a_enq) + CW'(b_enq)
              - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: random and directed writebacks
// checked against an in-order queue model with expected write cycles.
module tb_wb_write_arbiter;

  localparam int DEPTH = 4;

  logic clk;
  logic rst;
  logic a_valid, b_valid;
  logic [4:0] a_addr, b_addr;
  logic [31:0] a_data, b_data;
  logic a_ready, b_ready;
  logic write;
  logic [4:0] addrssw;
  logic [31:0] write_material;
  logic [31:0] pending;
  logic [$clog2(DEPTH):0] count;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_addr(a_addr),
    .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr),
    .b_data(b_data), .b_ready(b_ready),
    .write(write), .addrssw(addrssw),
    .write_material(write_material),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          c;
  } ent_t;

  ent_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_exp = 0;
  int max_cnt = 0;

  logic        av_s = 0, bv_s = 0;
  logic        acc_a_s = 0, acc_b_s = 0;
  logic [4:0]  aa_s = 0, ba_s = 0;
  logic [31:0] ad_s = 0, bd_s = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string nm,
                                logic [31:0] act,
                                logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h @cyc%0d",
               nm, act, exp, cyc);
    end
  endfunction

  // Monitor: compares presented head against the model queue
  always @(negedge clk) begin
    logic [31:0] pexp;
    ent_t e;
    if (rst) begin
      check("rst_write", {31'd0, write}, 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_pending", pending, 32'd0);
    end else begin
      pexp = '0;
      foreach (exp_q[i]) pexp[exp_q[i].a] = 1'b1;
      check("count", 32'(count), 32'(exp_q.size()));
      check("pending", pending, pexp);
      check("write", {31'd0, write},
            {31'd0, exp_q.size() != 0});
      if (int'(count) > max_cnt) max_cnt = int'(count);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addrssw), 32'(e.a));
        check("wr_data", write_material, e.d);
        check("wr_cycle", cyc, e.c);
      end else begin
        check("idle_addr", 32'(addrssw), 32'd0);
        check("idle_data", write_material, 32'd0);
      end
    end
  end

  task automatic push(input logic [4:0] a,
                      input logic [31:0] d);
    ent_t e;
    e.a = a;
    e.d = d;
    e.c = (cyc + 1 > last_exp + 1) ? cyc + 1 : last_exp + 1;
    last_exp = e.c;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic r,
                       input logic av,
                       input logic [4:0] aa,
                       input logic [31:0] ad,
                       input logic bv,
                       input logic [4:0] ba,
                       input logic [31:0] bd,
                       output logic acc_a,
                       output logic acc_b);
    int free;
    logic ea, eb;
    @(negedge clk);
    #1;
    rst = r;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    if (r) begin
      exp_q.delete();
      last_exp = 0;
    end
    #1;
    free = DEPTH - exp_q.size();
    ea = (free >= 1);
    eb = (free >= 2) || ((free >= 1) && !av);
    check("a_ready", {31'd0, a_ready}, {31'd0, ea});
    check("b_ready", {31'd0, b_ready}, {31'd0, eb});
    acc_a = av && ea && !r;
    acc_b = bv && eb && !r;
    if (acc_a && aa != 5'd0) push(aa, ad);
    if (acc_b) push(ba, bd);
  endtask

  task automatic idle(input int n);
    logic x, y;
    for (int i = 0; i < n; i++)
      cycle(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, x, y);
  endtask

  // Producers hold their request until it is accepted
  task automatic rnd_cycle(input int pa, input int pb,
                           input int amin);
    if (!(av_s && !acc_a_s)) begin
      av_s = ($urandom_range(0, 99) < pa);
      aa_s = 5'($urandom_range(amin, 31));
      ad_s = $urandom;
    end
    if (!(bv_s && !acc_b_s)) begin
      bv_s = ($urandom_range(0, 99) < pb);
      ba_s = 5'($urandom_range(0, 31));
      bd_s = $urandom;
    end
    cycle(0, av_s, aa_s, ad_s, bv_s, ba_s, bd_s,
          acc_a_s, acc_b_s);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    logic x, y;
    rst = 1;
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, x, y);
    cycle(1, 1, 5'd4, 32'h1, 1, 5'd6, 32'h2, x, y);
    idle(2);

    cycle(0, 1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, x, y);
    idle(3);
    cycle(0, 1, 5'd3, 32'h11, 1, 5'd3, 32'h22, x, y);
    idle(3);
    cycle(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, x, y);
    check("r0_acc", {31'd0, x}, 32'd1);
    idle(3);

    for (int i = 0; i < 300; i++) rnd_cycle(60, 50, 0);
    av_s = 0; bv_s = 0;
    idle(6);

    max_cnt = 0;
    for (int i = 0; i < 40; i++) rnd_cycle(100, 100, 1);
    check("full_peak", max_cnt, DEPTH);
    av_s = 0; bv_s = 0;
    idle(6);

    cycle(0, 1, 5'd7, 32'h7, 1, 5'd8, 32'h8, x, y);
    cycle(0, 1, 5'd9, 32'h9, 1, 5'd10, 32'hA, x, y);
    cycle(1, 1, 5'd11, 32'hB, 1, 5'd12, 32'hC, x, y);
    idle(4);

    max_cnt = 0;
    for (int i = 1; i < 32; i++)
      cycle(0, 1, 5'(i), $urandom, 0, 5'd0, 32'd0, x, y);
    idle(3);
    check("pass_peak", {31'd0, max_cnt <= 1}, 32'd1);

    for (int i = 0; i < 150; i++) begin
      if (i == 75)
        cycle(1, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
              acc_a_s, acc_b_s);
      else
        rnd_cycle(80, 80, 0);
    end
    av_s = 0; bv_s = 0;
    idle(8);
    check("drain", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_write_arbiter.md
WB_WRITE_ARBITER -- requirements
Module: wb_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, 2..16.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 a_valid  in  1  producer A (ALU path) has a writeback.
REQ-005 a_addr  in  5  producer A destination register.
REQ-006 a_data  in  32  producer A result.
REQ-007 a_ready  out  1  producer A request accepted this cycle when a_valid=1.
REQ-008 b_valid, b_addr, b_data, b_ready  as REQ-004..007, for producer B (load/multicycle path).
REQ-009 write  out  1  register-file write enable.
REQ-010 addrssw  out  5  register-file write address.
REQ-011 write_material  out  32  register-file write data.
REQ-012 pending  out  32  bit i = 1 while any queued entry targets register i.
REQ-013 count  out  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 The block SHALL hold a FIFO of DEPTH entries {addr[4:0], data[31:0]}, with read pointer, write pointer and count registers.
REQ-015 The head entry SHALL be presented combinationally: write = (count!=0), addrssw/write_material = head fields; both SHALL be 0 when empty.
REQ-016 The register file always accepts, so the head SHALL pop on every clock edge where count!=0.
REQ-017 free = DEPTH - count + (count!=0 ? 1 : 0); the slot freed by this cycle's pop SHALL be reusable in the same cycle.
REQ-018 a_ready = (free >= 1).
REQ-019 b_ready = (free >= 2) or (free >= 1 and a_valid = 0); A has priority when only one slot is free.
REQ-020 A handshake (valid & ready) with addr = 0 SHALL complete but SHALL NOT enqueue; writes to r0 are discarded.
REQ-021 When both A and B are accepted in one cycle, A SHALL be enqueued ahead of B, and both SHALL be written in that order.
REQ-022 count_next = count + enqueued(0..2) - popped(0..1); count SHALL never exceed DEPTH or go below 0.
REQ-023 Pointers SHALL wrap modulo DEPTH.
REQ-024 Latency: with an empty queue, a request accepted at edge N SHALL appear on write/addrssw/write_material during cycle N+1 and pop at edge N+1.
REQ-025 Duplicate destinations SHALL be preserved in order, with no merging; the later entry overwrites in the register file.
REQ-026 pending SHALL be computed combinationally from occupied entries only; a popping entry SHALL still count as pending during its write cycle.
REQ-027 A valid input not accepted SHALL NOT alter state; producers hold addr/data until ready.

Reset
REQ-028 With rst=1 at an edge, count, both pointers and all entries SHALL be cleared to 0; write=0, addrssw=0, write_material=0, pending=0.
REQ-029 Reset SHALL take priority over any simultaneous enqueue or pop; queued writes are dropped and never reach the register file.
REQ-030 During reset cycles, a_ready and b_ready SHALL reflect the empty queue; handshakes in those cycles SHALL be ignored.

Verification
REQ-031 Single write: empty queue, A {addr=5, data=0xDEADBEEF} for one cycle -> next cycle write=1, addrssw=5, write_material=0xDEADBEEF, pending=0x00000020; the following cycle write=0, pending=0.
REQ-032 Dual write: A {3, 0x11} and B {3, 0x22} in the same cycle -> writes on consecutive cycles, 0x11 then 0x22, both at addrssw=3.
REQ-033 r0 discard: A {0, 0xFFFFFFFF} -> a_ready=1 and count stays 0, with no write pulse.
REQ-034 Full/priority: DEPTH=4, B held valid while 2 A/B pairs per cycle fill the queue -> count peaks at 4; when free=1 with both valid, a_ready=1 and b_ready=0; no entry is lost or reordered across the wrap of the pointers.
REQ-035 Reset mid-operation: count=3, rst=1 for one edge -> count=0, write=0, pending=0 the next cycle; none of the 3 queued addresses are written.
REQ-036 Pass-through stream: A valid every cycle with addr 1..31 -> count never exceeds 1, and each write appears exactly one cycle after acceptance.
